dense_row_scheduler: RTL and testbench

//  Sequences a dense network through the dense/activate register pipeline: issues one
//  (w_layer_index, w_row_index) pair per accepted beat, forward over all layers, then

---
 rtl/dense_row_scheduler_pkg.sv | 20 ++
 rtl/dense_row_scheduler_if.sv | 26 ++
 rtl/dense_row_scheduler_row_layer_counter.sv | 69 ++++++
 rtl/dense_row_scheduler.sv | 127 ++++++++++++
 tb/tb_dense_row_scheduler.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dense_row_scheduler_pkg.sv
// Shared types and sizing helpers for the dense-layer row scheduler.
// Holds the state encoding and the width of the index outputs.
package dense_row_scheduler_pkg;

  localparam int IDX_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_DRAIN = 3'd2,
    S_BWD   = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  // Counter width for a bound n; a single-value counter still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dense_row_scheduler_if.sv
// Beat/control bundle between the scheduler and its controller and first pipeline stage.
// master = scheduler side, slave = controller / pipeline side.
interface dense_row_scheduler_if;

  logic                                       start;
  logic                                       train;
  logic                                       out_ready;
  logic                                       out_valid;
  logic [dense_row_scheduler_pkg::IDX_W-1:0]  w_layer_index;
  logic [dense_row_scheduler_pkg::IDX_W-1:0]  w_row_index;
  logic                                       is_update;
  logic                                       backprop_cost;
  logic                                       busy;
  logic                                       done;

  modport master (
    input  start, train, out_ready,
    output out_valid, w_layer_index, w_row_index, is_update, backprop_cost, busy, done
  );

  modport slave (
    output start, train, out_ready,
    input  out_valid, w_layer_index, w_row_index, is_update, backprop_cost, busy, done
  );

endinterface

// File: rtl/dense_row_scheduler_row_layer_counter.sv
// Nested row/layer counter: rows always count up, layers count up or down per load.
// Zero latency on last flag; advances only on adv, holds otherwise (including at the last beat).
module dense_row_scheduler_row_layer_counter
  import dense_row_scheduler_pkg::*;
#(
  parameter int num_layers = 3,
  parameter int size       = 3,
  parameter int LW         = cnt_w(num_layers),
  parameter int RW         = cnt_w(size)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          load_down,
  input  logic          adv,
  output logic [RW-1:0] row,
  output logic [LW-1:0] layer,
  output logic          last
);

  localparam logic [RW-1:0] ROW_MAX   = RW'(size - 1);
  localparam logic [LW-1:0] LAYER_MAX = LW'(num_layers - 1);

  logic [RW-1:0] row_q,   row_d;
  logic [LW-1:0] layer_q, layer_d;
  logic          down_q,  down_d;
  logic          row_end;
  logic [LW-1:0] layer_end;

  always_comb begin
    row_end   = (row_q == ROW_MAX);
    layer_end = down_q ? LW'(0) : LAYER_MAX;
    last      = row_end && (layer_q == layer_end);
  end

  always_comb begin
    row_d   = row_q;
    layer_d = layer_q;
    down_d  = down_q;
    if (load) begin
      row_d   = '0;
      down_d  = load_down;
      layer_d = load_down ? LAYER_MAX : LW'(0);
    end else if (adv && !last) begin
      if (row_end) begin
        row_d   = '0;
        layer_d = down_q ? (layer_q - LW'(1)) : (layer_q + LW'(1));
      end else begin
        row_d = row_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q   <= '0;
      layer_q <= '0;
      down_q  <= 1'b0;
    end else begin
      row_q   <= row_d;
      layer_q <= layer_d;
      down_q  <= down_d;
    end
  end

  assign row   = row_q;
  assign layer = layer_q;

endmodule

// File: rtl/dense_row_scheduler.sv
// Issues (layer,row) beats forward over all layers, drains, then optionally backward; done pulse at end.
// Beat outputs come straight from registers; on out_ready low every beat output holds.
module dense_row_scheduler
  import dense_row_scheduler_pkg::*;
#(
  parameter int num_layers   = 3,
  parameter int size         = 3,
  parameter int pipe_latency = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  dense_row_scheduler_if.master bus
);

  localparam int LW = cnt_w(num_layers);
  localparam int RW = cnt_w(size);
  localparam int DW = cnt_w(pipe_latency);

  localparam logic [DW-1:0] DRAIN_LOAD = DW'(pipe_latency - 1);
  localparam logic [LW-1:0] COST_LAYER = LW'(num_layers - 1);

  state_e        state_q, state_d;
  logic          train_q, train_d;
  logic [DW-1:0] drain_q, drain_d;

  logic          cnt_load;
  logic          cnt_load_down;
  logic          xfer;
  logic          valid;
  logic          last;
  logic [RW-1:0] row;
  logic [LW-1:0] layer;

  dense_row_scheduler_row_layer_counter #(
    .num_layers (num_layers),
    .size       (size)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .load_down (cnt_load_down),
    .adv       (xfer),
    .row       (row),
    .layer     (layer),
    .last      (last)
  );

  assign valid = (state_q == S_FWD) || (state_q == S_BWD);
  assign xfer  = valid && bus.out_ready;

  always_comb begin
    state_d       = state_q;
    train_d       = train_q;
    drain_d       = drain_q;
    cnt_load      = 1'b0;
    cnt_load_down = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_FWD;
          train_d  = bus.train;
          cnt_load = 1'b1;
        end
      end
      S_FWD: begin
        if (xfer && last) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          if (train_q) begin
            state_d       = S_BWD;
            cnt_load      = 1'b1;
            cnt_load_down = 1'b1;
          end else begin
            state_d = S_FIN;
          end
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      S_BWD: begin
        // Clearing train here makes the second drain fall through to FIN.
        if (xfer && last) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
          train_d = 1'b0;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      train_q <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      train_q <= train_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    bus.out_valid     = valid;
    bus.w_layer_index = '0;
    bus.w_row_index   = '0;
    if (valid) begin
      bus.w_layer_index = {{(IDX_W - LW){1'b0}}, layer};
      bus.w_row_index   = {{(IDX_W - RW){1'b0}}, row};
    end
    bus.is_update     = (state_q == S_BWD);
    bus.backprop_cost = (state_q == S_BWD) && (layer == COST_LAYER);
    bus.busy          = (state_q != S_IDLE);
    bus.done          = (state_q == S_FIN);
  end

endmodule

// File: tb/tb_dense_row_scheduler.sv
// Table-driven check of the scheduler: default 3x3x4 instance (A) and a 1x1x1 instance (B).
module tb_dense_row_scheduler;

  typedef struct {
    bit start;
    bit train;
    bit ready;
    bit valid;
    int layer;
    int row;
    bit upd;
    bit cost;
    bit busy;
    bit done;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   xfer_a;
  int   done_a;
  int   done_b;
  vec_t tbl[$];

  dense_row_scheduler_if ifa();
  dense_row_scheduler_if ifb();

  dense_row_scheduler u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  dense_row_scheduler #(
    .num_layers   (1),
    .size         (1),
    .pipe_latency (1)
  ) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ifa.out_valid && ifa.out_ready) xfer_a++;
    if (ifa.done) done_a++;
    if (ifb.done) done_b++;
  end

  function automatic vec_t mk(input bit s, input bit t, input bit r, input bit v,
                              input int l, input int rw, input bit u, input bit c,
                              input bit b, input bit d);
    vec_t x;
    x.start = s; x.train = t; x.ready = r; x.valid = v;
    x.layer = l; x.row = rw; x.upd = u; x.cost = c; x.busy = b; x.done = d;
    return x;
  endfunction

  task automatic check_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Forward beats in order; the first carries start/train, optional stall at (sl,sr).
  task automatic add_fwd(input int nl, input int sz, input bit tr,
                         input int sl, input int sr, input int sn);
    for (int l = 0; l < nl; l++) begin
      for (int r = 0; r < sz; r++) begin
        tbl.push_back(mk(l == 0 && r == 0, tr, 1'b1, 1'b1, l, r, 1'b0, 1'b0, 1'b1, 1'b0));
        if (l == sl && r == sr) begin
          for (int k = 0; k < sn; k++)
            tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, l, r, 1'b0, 1'b0, 1'b1, 1'b0));
        end
      end
    end
  endtask

  task automatic add_bwd(input int nl, input int sz, input int stop_l, input int stop_r);
    for (int l = nl - 1; l >= 0; l--) begin
      for (int r = 0; r < sz; r++) begin
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, l, r, 1'b1, l == nl - 1, 1'b1, 1'b0));
        if (l == stop_l && r == stop_r) return;
      end
    end
  endtask

  task automatic add_drain(input int n);
    for (int k = 0; k < n; k++)
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic add_fin();
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Inputs of a vector are driven for one cycle; its expected outputs are those after that edge.
  task automatic run_tbl(input bit sel, input string nm);
    logic [31:0] gl, gr;
    logic        gv, gu, gc, gb, gd;
    for (int i = 0; i < tbl.size(); i++) begin
      if (!sel) begin
        ifa.start = tbl[i].start; ifa.train = tbl[i].train; ifa.out_ready = tbl[i].ready;
      end else begin
        ifb.start = tbl[i].start; ifb.train = tbl[i].train; ifb.out_ready = tbl[i].ready;
      end
      @(posedge clk);
      @(negedge clk);
      if (!sel) begin
        gv = ifa.out_valid; gl = ifa.w_layer_index; gr = ifa.w_row_index;
        gu = ifa.is_update; gc = ifa.backprop_cost; gb = ifa.busy; gd = ifa.done;
      end else begin
        gv = ifb.out_valid; gl = ifb.w_layer_index; gr = ifb.w_row_index;
        gu = ifb.is_update; gc = ifb.backprop_cost; gb = ifb.busy; gd = ifb.done;
      end
      n_checks++;
      if (gv !== tbl[i].valid || gu !== tbl[i].upd || gc !== tbl[i].cost ||
          gb !== tbl[i].busy || gd !== tbl[i].done ||
          (tbl[i].valid && (gl !== 32'(tbl[i].layer) || gr !== 32'(tbl[i].row)))) begin
        n_fail++;
        $display("FAIL %s[%0d]: got v=%0b L=%0d R=%0d upd=%0b cost=%0b busy=%0b done=%0b, expected v=%0b L=%0d R=%0d upd=%0b cost=%0b busy=%0b done=%0b",
                 nm, i, gv, gl, gr, gu, gc, gb, gd, tbl[i].valid, tbl[i].layer, tbl[i].row,
                 tbl[i].upd, tbl[i].cost, tbl[i].busy, tbl[i].done);
      end
    end
    tbl.delete();
  endtask

  task automatic check_zero_a(input string nm);
    n_checks++;
    if ({ifa.out_valid, ifa.w_layer_index, ifa.w_row_index, ifa.is_update,
         ifa.backprop_cost, ifa.busy, ifa.done} !== 70'd0) begin
      n_fail++;
      $display("FAIL %s: got v=%0b L=%0d R=%0d upd=%0b cost=%0b busy=%0b done=%0b, expected all zero",
               nm, ifa.out_valid, ifa.w_layer_index, ifa.w_row_index, ifa.is_update,
               ifa.backprop_cost, ifa.busy, ifa.done);
    end
  endtask

  initial begin
    int base_x, base_d, base_b;
    n_checks = 0; n_fail = 0; xfer_a = 0; done_a = 0; done_b = 0;
    reset = 1'b1;
    ifa.start = 1'b0; ifa.train = 1'b0; ifa.out_ready = 1'b1;
    ifb.start = 1'b0; ifb.train = 1'b0; ifb.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_a("reset_a");
    n_checks++;
    if ({ifb.out_valid, ifb.w_layer_index, ifb.w_row_index, ifb.is_update,
         ifb.backprop_cost, ifb.busy, ifb.done} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_b: got v=%0b busy=%0b done=%0b, expected all zero",
               ifb.out_valid, ifb.busy, ifb.done);
    end
    reset = 1'b0;

    // Inference run
    base_x = xfer_a; base_d = done_a;
    add_fwd(3, 3, 1'b0, -1, -1, 0);
    add_drain(4);
    add_fin();
    run_tbl(1'b0, "infer");
    check_int("infer_xfers", xfer_a - base_x, 9);
    check_int("infer_done", done_a - base_d, 1);

    // Training run
    base_x = xfer_a; base_d = done_a;
    add_fwd(3, 3, 1'b1, -1, -1, 0);
    add_drain(4);
    add_bwd(3, 3, -1, -1);
    add_drain(4);
    add_fin();
    run_tbl(1'b0, "train");
    check_int("train_xfers", xfer_a - base_x, 18);
    check_int("train_done", done_a - base_d, 1);

    // Backpressure: out_ready low for 3 cycles while (1,1) is presented
    base_x = xfer_a;
    add_fwd(3, 3, 1'b0, 1, 1, 3);
    add_drain(4);
    add_fin();
    run_tbl(1'b0, "stall");
    check_int("stall_xfers", xfer_a - base_x, 9);

    // start pulsed during FWD and DRAIN is ignored
    base_d = done_a;
    add_fwd(3, 3, 1'b0, -1, -1, 0);
    add_drain(4);
    add_fin();
    tbl[3].start = 1'b1;
    tbl[10].start = 1'b1;
    run_tbl(1'b0, "start_ignored");
    check_int("start_ignored_done", done_a - base_d, 1);

    // Reset while BWD beat (1,2) is presented
    base_d = done_a;
    add_fwd(3, 3, 1'b1, -1, -1, 0);
    add_drain(4);
    add_bwd(3, 3, 1, 2);
    run_tbl(1'b0, "pre_abort");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero_a("abort_outputs");
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_int("abort_no_done", done_a - base_d, 0);
    base_x = xfer_a; base_d = done_a;
    add_fwd(3, 3, 1'b1, -1, -1, 0);
    add_drain(4);
    add_bwd(3, 3, -1, -1);
    add_drain(4);
    add_fin();
    run_tbl(1'b0, "after_abort");
    check_int("after_abort_xfers", xfer_a - base_x, 18);
    check_int("after_abort_done", done_a - base_d, 1);

    // Minimal instance: training run then back-to-back inference
    base_b = done_b;
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    run_tbl(1'b1, "min");
    check_int("min_done", done_b - base_b, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
